fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the five-stage pipelined core. It sits directly upstream of the decode-stage controller.
- Owns the PC and drives the instruction-memory request/response handshake.
- Captures fetched instructions into IF/ID and presents the decode fields opD/funct3D/funct7b5D/Rs1D/Rs2D/RdD.
- Honours stallD, flushD and the execute-stage redirect (PCSrcE/PCTargetE).

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP, 32'h0000_0013, instruction driven on InstrD when IF/ID is empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch address (PCF).
- imem_rsp_valid  in  1  response valid; no back-pressure, exactly one response per accepted request, in order.
- imem_rsp_data  in  32  fetched instruction.
- stallD  in  1  hold IF/ID.
- flushD  in  1  invalidate IF/ID and skid.
- PCSrcE  in  1  redirect from execute.
- PCTargetE  in  XLEN  redirect target.
- ValidD  out  1  IF/ID holds a live instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4, registered.
- opD  out  7  InstrD[6:0].
- funct3D  out  3  InstrD[14:12].
- funct7b5D  out  1  InstrD[30].
- Rs1D  out  5  InstrD[19:15].
- Rs2D  out  5  InstrD[24:20].
- RdD  out  5  InstrD[11:7].

Behaviour:
- Reset (async, active-low) sets state=REQ, PCF=RESET_PC, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0, skid empty. Instruction memory shares this reset, so no stale response survives reset. Reset mid-request abandons the request.
- Maximum one outstanding request. Each request carries a tag-free address register reqPC = PCF at acceptance.
- FSM states:
  - REQ: imem_req_valid=1. On handshake → WAIT and PCF<=PCF+4.
  - WAIT: wait for the response.
  - KILL: the next response is discarded. On rsp_valid → REQ.
- WAIT, on rsp_valid with no redirect:
  - If the IF/ID register can load (stallD=0 or ValidD=0) and skid is empty, load IF/ID with {rsp_data, reqPC, reqPC+4} and ValidD=1.
  - Otherwise write the response to the skid buffer (1 entry).
- Back-to-back issue: in WAIT, with rsp_valid, the response loading IF/ID directly and PCSrcE=0, also assert imem_req_valid with addr=PCF in the same cycle.
  - If accepted: stay in WAIT and PCF+=4.
  - Otherwise: go to REQ.
  - With a zero-wait memory this gives one instruction per cycle.
- Skid non-empty: no new request is issued. When IF/ID can load, skid moves to IF/ID, skid empties, and the FSM goes to REQ.
- stallD=1 with ValidD=1: IF/ID holds all fields.
- flushD=1 (priority over stallD): next cycle ValidD=0, InstrD=NOP, and skid is cleared. A response arriving in the same cycle as flushD is discarded.
- PCSrcE=1 (highest priority):
  - PCF<=PCTargetE.
  - An outstanding request (WAIT, or a REQ handshake in this same cycle) → KILL.
  - With no request in flight → REQ.
  - No request is issued in the redirect cycle.
  - A redirect while in KILL updates PCF only; a second kill is not needed because at most one request is outstanding.
- A response arriving in the redirect cycle is discarded.
- Response arriving in REQ: illegal, assertion only.
- PC arithmetic is modulo 2^XLEN; wrap from 0xFFFF_FFFC to 0 is legal.
- Decode field outputs are pure slices of InstrD, so when ValidD=0 they decode as NOP.

Decomposition:
- Shared package: fetch-state enum {REQ, WAIT, KILL}, NOP constant, RESET_PC default.
- One natural sub-module: fetch_skid, a 1-entry {instr, pc} holding register with load/drain/clear.
- The IF/ID register uses the existing enable/clear flop primitives.

Test Plan:
- Reset release, zero-wait memory (ready=1, rsp one cycle after accept), instructions I0..I3 → imem_req_addr 0,4,8,12 on consecutive cycles. InstrD=I0..I3 with PCD=0,4,8,12 on cycles 2..5. ValidD rises in cycle 2.
- req_ready held low 3 cycles after reset → imem_req_valid=1 with addr 0 throughout, ValidD stays 0, PCF stays 0 until acceptance.
- stallD high 2 cycles while I1 response arrives → I1 goes to skid and no new request is issued. InstrD holds I0. After stallD drops, InstrD=I1 next cycle, then fetch resumes at addr 8.
- PCSrcE=1 with PCTargetE=0x100 while in WAIT for addr 8 → response for 8 discarded (never reaches InstrD). Next request addr=0x100. InstrD=instr@0x100 with PCD=0x100.
- flushD and stallD together with the skid full → ValidD=0, InstrD=0x0000_0013, skid empty next cycle.
- PCTargetE=0xFFFF_FFFC → fetch addr 0xFFFF_FFFC then 0x0. PCPlus4D=0x0 for the first instruction.
- Reset asserted mid-WAIT → outputs immediately at reset values. After release, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-state encoding and default constants
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_skid.sv
// rtl/fetch_stage_skid.sv - one-entry {instr, pc} holding register for a blocked response
module fetch_skid #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_drain,
  input  logic            i_clear,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  // Clear beats load beats drain; load and drain never coincide because
  // the entry only fills while it is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem handshake, skid entry and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [6:0]      opD,
  output logic [2:0]      funct3D,
  output logic            funct7b5D,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_req_pc;
  logic            r_valid_d;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc4_d;

  logic            w_ifid_can_load;
  logic            w_rsp_live;
  logic            w_rsp_to_ifid;
  logic            w_rsp_to_skid;
  logic            w_skid_drain;
  logic            w_skid_valid;
  logic [31:0]     w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;
  logic            w_req_fire;

  // A response is kept only if it belongs to a live request and neither a
  // redirect nor a flush is discarding it this cycle.
  assign w_ifid_can_load = !stallD || !r_valid_d;
  assign w_rsp_live      = (r_state == S_WAIT) && imem_rsp_valid && !PCSrcE && !flushD;
  assign w_rsp_to_ifid   = w_rsp_live && w_ifid_can_load && !w_skid_valid;
  assign w_rsp_to_skid   = w_rsp_live && !w_rsp_to_ifid;
  assign w_skid_drain    = w_skid_valid && w_ifid_can_load && !flushD;

  // Back-to-back issue only when the current response goes straight into IF/ID.
  assign imem_req_valid  = !PCSrcE && !w_skid_valid && ((r_state == S_REQ) || w_rsp_to_ifid);
  assign imem_req_addr   = r_pcf;
  assign w_req_fire      = imem_req_valid && imem_req_ready;

  fetch_skid #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_rsp_to_skid),
    .i_instr (imem_rsp_data),
    .i_pc    (r_req_pc),
    .i_drain (w_skid_drain),
    .i_clear (flushD),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // Fetch FSM and PC: a redirect wins; a request still in flight must be killed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_REQ;
      r_pcf    <= RESET_PC;
      r_req_pc <= '0;
    end else if (PCSrcE) begin
      r_pcf   <= PCTargetE;
      r_state <= ((r_state == S_WAIT || r_state == S_KILL) && !imem_rsp_valid) ? S_KILL : S_REQ;
    end else begin
      if (w_req_fire) begin
        r_pcf    <= r_pcf + PC_STEP;
        r_req_pc <= r_pcf;
      end
      unique case (r_state)
        S_REQ:   if (w_req_fire) r_state <= S_WAIT;
        S_WAIT:  if (imem_rsp_valid) r_state <= w_req_fire ? S_WAIT : S_REQ;
        S_KILL:  if (imem_rsp_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

  // IF/ID register: flush, then skid drain, then direct response, else bubble unless stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
    end else if (flushD) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP;
    end else if (w_skid_drain) begin
      r_valid_d <= 1'b1;
      r_instr_d <= w_skid_instr;
      r_pc_d    <= w_skid_pc;
      r_pc4_d   <= w_skid_pc + PC_STEP;
    end else if (w_rsp_to_ifid) begin
      r_valid_d <= 1'b1;
      r_instr_d <= imem_rsp_data;
      r_pc_d    <= r_req_pc;
      r_pc4_d   <= r_req_pc + PC_STEP;
    end else if (w_ifid_can_load) begin
      r_valid_d <= 1'b0;
      r_instr_d <= NOP;
    end
  end

  assign ValidD    = r_valid_d;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc4_d;
  assign opD       = r_instr_d[6:0];
  assign funct3D   = r_instr_d[14:12];
  assign funct7b5D = r_instr_d[30];
  assign Rs1D      = r_instr_d[19:15];
  assign Rs2D      = r_instr_d[24:20];
  assign RdD       = r_instr_d[11:7];

`ifndef SYNTHESIS
  // Memory must never answer when no request is outstanding.
  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!reset)
    !(r_state == S_REQ && imem_rsp_valid));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed cycle vectors
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic        funct7b5D;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mem_lat  = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[24:0], 7'h33};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = instr_of(pc);
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    sb.push_back(e);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: one response mem_lat cycles after each accepted request; shares reset.
  initial begin
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] paddr;
    int          pcnt;
    bit          pend;
    pend  = 1'b0;
    pcnt  = 0;
    paddr = 32'd0;
    forever begin
      @(negedge clk);
      fire  = reset && imem_req_valid && imem_req_ready;
      faddr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (fire) begin
          pend  = 1'b1;
          paddr = faddr;
          pcnt  = mem_lat;
        end
        if (pend) begin
          pcnt--;
          if (pcnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(paddr);
            pend           = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: decode consumes IF/ID whenever it is valid and not stalled or flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ValidD && !stallD && !flushD) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got instr %h pc %h, expected none", InstrD, PCD);
        end else begin
          e = sb.pop_front();
          check("sb_instr", InstrD, e.instr);
          check("sb_pcd", PCD, e.pc);
          check("sb_pc4", PCPlus4D, e.pc4);
          check("sb_fields", {6'd0, opD, funct3D, funct7b5D, Rs1D, Rs2D, RdD},
                {6'd0, e.instr[6:0], e.instr[14:12], e.instr[30], e.instr[19:15],
                 e.instr[24:20], e.instr[11:7]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Directed stimulus; inputs change 2 time units after each rising edge.
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ValidD), 32'd0);
    check("rst_instr", InstrD, 32'h0000_0013);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pc4", PCPlus4D, 32'd0);
    check("rst_addr", imem_req_addr, 32'd0);
    next_cycle;
    reset = 1'b1;

    // Memory not ready for three cycles.
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      check("nrdy_req_valid", 32'(imem_req_valid), 32'd1);
      check("nrdy_addr", imem_req_addr, 32'd0);
      check("nrdy_validd", 32'(ValidD), 32'd0);
      next_cycle;
    end

    // Zero-wait streaming of I0..I3.
    for (int i = 0; i < 4; i++) push(32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      imem_req_ready = (i < 4);
      @(negedge clk);
      if (i < 4) begin
        check("stream_req_valid", 32'(imem_req_valid), 32'd1);
        check("stream_addr", imem_req_addr, 32'(4 * i));
      end
      if (i == 1) check("stream_validd_c1", 32'(ValidD), 32'd0);
      if (i == 2) check("stream_validd_c2", 32'(ValidD), 32'd1);
      next_cycle;
    end

    // Stall/skid, redirect with kill, flush with full skid, PC wrap, reset mid-WAIT.
    push(32'd16);
    push(32'd20);
    push(32'h100);
    push(32'hFFFF_FFFC);
    push(32'd0);
    for (int b = 0; b < 29; b++) begin
      imem_req_ready = 1'b0;
      stallD = 1'b0;
      flushD = 1'b0;
      PCSrcE = 1'b0;
      case (b)
        0, 1:   imem_req_ready = 1'b1;
        2, 3:   stallD = 1'b1;
        4:      mem_lat = 2;
        5:      imem_req_ready = 1'b1;
        6: begin PCSrcE = 1'b1; PCTargetE = 32'h100; imem_req_ready = 1'b1; end
        8:      imem_req_ready = 1'b1;
        10:     mem_lat = 1;
        11, 12: imem_req_ready = 1'b1;
        13:     stallD = 1'b1;
        14: begin stallD = 1'b1; flushD = 1'b1; end
        16: begin PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; end
        17, 18: imem_req_ready = 1'b1;
        20: begin stallD = 1'b1; imem_req_ready = 1'b1; mem_lat = 3; end
        21:     stallD = 1'b1;
        22: begin reset = 1'b1; mem_lat = 1; imem_req_ready = 1'b1; end
        default: ;
      endcase
      if (b == 21) begin
        #1;
        reset = 1'b0;
        #1;
        check("midrst_validd", 32'(ValidD), 32'd0);
        check("midrst_instr", InstrD, 32'h0000_0013);
        check("midrst_pcd", PCD, 32'd0);
        check("midrst_pc4", PCPlus4D, 32'd0);
        check("midrst_addr", imem_req_addr, 32'd0);
      end
      @(negedge clk);
      case (b)
        0:  check("stall_addr16", imem_req_addr, 32'd16);
        2:  check("skid_noreq_b2", 32'(imem_req_valid), 32'd0);
        3: begin
          check("skid_noreq_b3", 32'(imem_req_valid), 32'd0);
          check("stall_hold_instr", InstrD, instr_of(32'd16));
        end
        4:  check("skid_noreq_b4", 32'(imem_req_valid), 32'd0);
        5: begin
          check("resume_req_valid", 32'(imem_req_valid), 32'd1);
          check("resume_addr", imem_req_addr, 32'd24);
        end
        6:  check("redir_noreq", 32'(imem_req_valid), 32'd0);
        7:  check("kill_noreq", 32'(imem_req_valid), 32'd0);
        8: begin
          check("redir_addr", imem_req_addr, 32'h100);
          check("killed_not_loaded", 32'(ValidD), 32'd0);
        end
        10: check("b2b_addr_104", {imem_req_addr[31:1], imem_req_valid}, 32'h105);
        12: check("b2b_addr_108", {imem_req_addr[31:1], imem_req_valid}, 32'h109);
        14: check("flush_skidfull_noreq", 32'(imem_req_valid), 32'd0);
        15: begin
          check("flush_validd", 32'(ValidD), 32'd0);
          check("flush_instr", InstrD, 32'h0000_0013);
          check("flush_opd", 32'(opD), 32'h13);
          check("flush_skid_empty_req", {imem_req_addr[31:1], imem_req_valid}, 32'h10D);
        end
        16: check("redir2_noreq", 32'(imem_req_valid), 32'd0);
        17: check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        18: check("wrap_addr_zero", {imem_req_addr[31:1], imem_req_valid}, 32'h1);
        19: check("wrap_pc4", PCPlus4D, 32'd0);
        22: check("postrst_addr", {imem_req_addr[31:1], imem_req_valid}, 32'h1);
        23: check("postrst_b2b", {imem_req_addr[31:1], imem_req_valid}, 32'h5);
        default: ;
      endcase
      next_cycle;
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
